classifier_ctrl: RTL and testbench
==================================

CLASSIFIER_CTRL -- requirements
Module: classifier_ctrl

Interface
REQ-001 SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 clk  in  1  system clock, all state updates on rising edge.
REQ-003 rst  in  1  asynchronous active-high reset.
REQ-004 start  in  1  single-cycle request to classify one image.
REQ-005 row_select  out  4  row index driven to multiplier, 0..9.
REQ-006 begin_mult  out  1  one-cycle pulse launching the multiplier on row_select.
REQ-007 done_row  in  1  multiplier row-complete strobe.
REQ-008 w_result_ena  in  1  multiplier result-valid strobe.
REQ-009 row_result  in  32  signed two's-complement row score.
REQ-010 overflow  in  1  multiplier overflow flag, valid with done_row.
REQ-011 busy  out  1  high from accepted start until done or err.
REQ-012 done  out  1  one-cycle pulse, classification complete.
REQ-013 class_out  out  4  argmax row index, held until next accepted start.
REQ-014 max_score  out  32  score of class_out, held likewise.
REQ-015 ovf_any  out  1  sticky OR of overflow over current image's rows.
REQ-016 err  out  1  timeout flag, held until next accepted start.

Function
REQ-017 States SHALL be IDLE, LAUNCH, WAIT, STORE, FINISH, ERROR.
REQ-018 IDLE: start=1 -> LAUNCH; row counter 0, ovf_any, err, class_out, max_score cleared.
REQ-019 LAUNCH: begin_mult=1 for exactly one cycle, then WAIT; start at cycle N gives begin_mult at N+1.
REQ-020 row_select SHALL be stable from LAUNCH until the STORE cycle for that row.
REQ-021 WAIT: row_result captured on any cycle with w_result_ena=1; last capture wins.
REQ-022 WAIT: done_row=1 -> STORE; if no w_result_ena seen this row, row_result captured on the done_row cycle; both same cycle -> capture then advance.
REQ-023 overflow sampled on the done_row cycle and ORed into ovf_any.
REQ-024 STORE: row 0 loads max_score/class_out unconditionally; later rows replace only if captured score > max_score (signed, strict; ties keep lower index).
REQ-025 STORE: row < 9 -> increment row, LAUNCH (next begin_mult two cycles after done_row); row 9 -> FINISH.
REQ-026 FINISH: done=1 one cycle, busy=0, -> IDLE.
REQ-027 Watchdog counter SHALL clear on LAUNCH, count in WAIT; reaching TIMEOUT_CYCLES (1023) without done_row -> ERROR.
REQ-028 ERROR: err=1, busy=0, no done pulse; start=1 -> LAUNCH with clearing per REQ-018.
REQ-029 start while busy SHALL be ignored; done_row/w_result_ena outside WAIT SHALL be ignored.

Reset
REQ-030 Reset SHALL force IDLE and zero row_select, begin_mult, busy, done, class_out, max_score, ovf_any, err, watchdog.
REQ-031 Reset mid-image SHALL abandon the image; no done pulse follows.

Structure
REQ-032 Package classifier_pkg SHALL hold the state enum, NUM_ROWS=10, ROW_W=4, SCORE_W=32, TIMEOUT_CYCLES=1023.
REQ-033 Watchdog SHALL be sub-module timeout_counter (10-bit, clear, enable, rollover flag).

Verification
REQ-034 Behavioral multiplier model, scores {5,-3,40,40,7,0,-100,12,39,1}, done_row 400 cycles after begin_mult -> class_out=2, max_score=40, ovf_any=0, one done pulse.
REQ-035 All scores negative {-9,-2,-50,...,-7} -> class_out=1, max_score=-2 (signed compare).
REQ-036 overflow=1 on row 6 only -> ovf_any=1 at done, class result unaffected.
REQ-037 Model withholds done_row on row 3 -> err=1 after 1023 WAIT cycles, busy=0, no done; then start -> row 0 relaunched, err cleared.
REQ-038 start pulsed during row 4 -> ignored, exactly 10 begin_mult pulses, row_select 0..9 in order.
REQ-039 rst asserted during row 5 WAIT -> all outputs zero immediately, IDLE, no done; next start classifies normally.

Source files
------------

// File: rtl/classifier_pkg.sv
// Shared types and sizing for the row-argmax classifier controller.
// Included first so every other file can import it.
package classifier_pkg;

  localparam int unsigned NUM_ROWS       = 10;
  localparam int unsigned ROW_W          = 4;
  localparam int unsigned SCORE_W        = 32;
  localparam int unsigned TIMEOUT_CYCLES = 1023;
  localparam int unsigned WDOG_W         = 10;

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StWait,
    StStore,
    StFinish,
    StError
  } state_e;

  // Row scores are two's-complement; comparisons must be signed.
  function automatic logic score_gt(logic [SCORE_W-1:0] a, logic [SCORE_W-1:0] b);
    return $signed(a) > $signed(b);
  endfunction

endpackage

// File: rtl/timeout_counter.sv
// Watchdog counter: synchronous clear, count enable, and a flag marking that the
// next enabled cycle takes the count to Limit (where it wraps back to zero).
module timeout_counter #(
  parameter int unsigned Width = 10,
  parameter int unsigned Limit = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [Width-1:0] count,
  output logic             rollover
);

  logic [Width-1:0] count_q, count_d;

  // Independent of enable so the controller can use it without a combinational loop.
  assign rollover = (count_q == Width'(Limit - 1));
  assign count    = count_q;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = rollover ? '0 : count_q + Width'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/classifier_ctrl.sv
// Sequences one multiplier run per row, tracks the signed argmax over all rows,
// and aborts to an error state if a row never completes.
module classifier_ctrl
  import classifier_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [ROW_W-1:0]   row_select,
  output logic               begin_mult,
  input  logic               done_row,
  input  logic               w_result_ena,
  input  logic [SCORE_W-1:0] row_result,
  input  logic               overflow,
  output logic               busy,
  output logic               done,
  output logic [ROW_W-1:0]   class_out,
  output logic [SCORE_W-1:0] max_score,
  output logic               ovf_any,
  output logic               err
);

  state_e             state_q, state_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               seen_q, seen_d;
  logic [ROW_W-1:0]   class_q, class_d;
  logic [SCORE_W-1:0] max_q, max_d;
  logic               ovf_q, ovf_d;
  logic               err_q, err_d;

  logic               wd_clear, wd_enable, wd_rollover;
  logic [WDOG_W-1:0]  wd_count;

  timeout_counter #(
    .Width (WDOG_W),
    .Limit (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clear    (wd_clear),
    .enable   (wd_enable),
    .count    (wd_count),
    .rollover (wd_rollover)
  );

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    score_d    = score_q;
    seen_d     = seen_q;
    class_d    = class_q;
    max_d      = max_q;
    ovf_d      = ovf_q;
    err_d      = err_q;
    begin_mult = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    wd_clear   = 1'b0;
    wd_enable  = 1'b0;

    unique case (state_q)
      StIdle, StError: begin
        if (start) begin
          state_d = StLaunch;
          row_d   = '0;
          class_d = '0;
          max_d   = '0;
          ovf_d   = 1'b0;
          err_d   = 1'b0;
        end
      end

      StLaunch: begin
        begin_mult = 1'b1;
        busy       = 1'b1;
        wd_clear   = 1'b1;
        seen_d     = 1'b0;
        state_d    = StWait;
      end

      StWait: begin
        busy = 1'b1;
        // A strobe always captures; done_row alone only captures if no strobe came this row.
        if (w_result_ena) begin
          score_d = row_result;
          seen_d  = 1'b1;
        end else if (done_row && !seen_q) begin
          score_d = row_result;
        end
        if (done_row) begin
          ovf_d   = ovf_q | overflow;
          state_d = StStore;
        end else begin
          wd_enable = 1'b1;
          if (wd_rollover) begin
            err_d   = 1'b1;
            state_d = StError;
          end
        end
      end

      StStore: begin
        busy = 1'b1;
        // Strict compare keeps the lower index on ties.
        if (row_q == '0 || score_gt(score_q, max_q)) begin
          max_d   = score_q;
          class_d = row_q;
        end
        if (row_q == LAST_ROW) begin
          state_d = StFinish;
        end else begin
          row_d   = row_q + ROW_W'(1);
          state_d = StLaunch;
        end
      end

      StFinish: begin
        done    = 1'b1;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      row_q   <= '0;
      score_q <= '0;
      seen_q  <= 1'b0;
      class_q <= '0;
      max_q   <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      score_q <= score_d;
      seen_q  <= seen_d;
      class_q <= class_d;
      max_q   <= max_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  assign row_select = row_q;
  assign class_out  = class_q;
  assign max_score  = max_q;
  assign ovf_any    = ovf_q;
  assign err        = err_q;

endmodule

// File: tb/tb_classifier_ctrl.sv
// Bench for classifier_ctrl: behavioural multiplier model plus a result scoreboard
// filled at start and drained on each done pulse.
module tb_classifier_ctrl;
  import classifier_pkg::*;

  logic        tb_clk = 1'b0;
  logic        rst, start;
  logic [3:0]  row_select, class_out;
  logic        begin_mult, busy, done, ovf_any, err;
  logic        done_row, w_result_ena, overflow;
  logic [31:0] row_result, max_score;

  classifier_ctrl dut (
    .clk          (tb_clk),
    .rst          (rst),
    .start        (start),
    .row_select   (row_select),
    .begin_mult   (begin_mult),
    .done_row     (done_row),
    .w_result_ena (w_result_ena),
    .row_result   (row_result),
    .overflow     (overflow),
    .busy         (busy),
    .done         (done),
    .class_out    (class_out),
    .max_score    (max_score),
    .ovf_any      (ovf_any),
    .err          (err)
  );

  always #5 tb_clk = ~tb_clk;

  typedef struct {
    logic [3:0]  cls;
    logic [31:0] score;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  // Multiplier model controls
  logic signed [31:0] scores [10];
  int mdelay   = 20;
  int mode     = 0;   // 0: strobe with done, 1: early strobes only, 2: done only
  int ovf_row  = -1;
  int hold_row = -1;

  int begin_cnt = 0;
  int done_cnt  = 0;
  int exp_row   = 0;

  localparam logic [31:0] JUNK = 32'h7FFF_FFFF;

  initial begin : mult_model
    int  cnt;
    int  mrow;
    bit  pend;
    done_row = 1'b0; w_result_ena = 1'b0; overflow = 1'b0; row_result = '0;
    cnt = 0; mrow = 0; pend = 1'b0;
    forever begin
      @(negedge tb_clk);
      done_row = 1'b0; w_result_ena = 1'b0; overflow = 1'b0; row_result = JUNK;
      if (rst === 1'b1) begin
        pend = 1'b0;
      end else if (pend) begin
        cnt--;
        if (mode == 1 && cnt == mdelay - 2) begin
          w_result_ena = 1'b1; row_result = scores[mrow] + 1000;
        end
        if (mode == 1 && cnt == mdelay / 2) begin
          w_result_ena = 1'b1; row_result = scores[mrow];
        end
        if (cnt == 0) begin
          pend     = 1'b0;
          done_row = 1'b1;
          overflow = (mrow == ovf_row);
          if (mode != 1) row_result = scores[mrow];
          if (mode == 0) w_result_ena = 1'b1;
        end
      end else if (begin_mult === 1'b1) begin
        mrow = int'(row_select);
        pend = (mrow != hold_row);
        cnt  = mdelay;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge tb_clk);
      if (begin_mult === 1'b1) begin
        begin_cnt++;
        tests++;
        if (row_select !== 4'(exp_row)) begin
          fails++;
          $display("FAIL row_order: row_select=%0d expected %0d", row_select, exp_row);
        end
        exp_row++;
      end
      if (done === 1'b1) begin
        done_cnt++;
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_done: done pulse with no image expected");
        end else begin
          e = sb.pop_front();
          if (class_out !== e.cls || max_score !== e.score || ovf_any !== e.ovf) begin
            fails++;
            $display("FAIL result: class=%0d score=%0d ovf=%b expected class=%0d score=%0d ovf=%b",
                     class_out, $signed(max_score), ovf_any, e.cls, $signed(e.score), e.ovf);
          end
        end
      end
    end
  end

  task automatic pulse_start();
    @(negedge tb_clk); start = 1'b1;
    @(negedge tb_clk); start = 1'b0;
  endtask

  task automatic run_image(input string name, input logic [3:0] ecls, input logic [31:0] escore,
                           input logic eovf, input int inj_row);
    int n;
    int inj;
    sb.push_back('{ecls, escore, eovf});
    exp_row = 0; begin_cnt = 0; done_cnt = 0;
    pulse_start();
    tests++;
    if (begin_mult !== 1'b1 || busy !== 1'b1 || err !== 1'b0) begin
      fails++;
      $display("FAIL %s_launch: begin_mult=%b busy=%b err=%b expected 1 1 0", name, begin_mult,
               busy, err);
    end
    n = 0; inj = 0;
    while (done !== 1'b1 && n < 20000) begin
      @(negedge tb_clk); n++;
      if (inj_row >= 0 && begin_mult === 1'b1 && int'(row_select) == inj_row) inj = 4;
      start = (inj > 0);
      if (inj > 0) inj--;
    end
    start = 1'b0;
    tests++;
    if (n >= 20000) begin
      fails++;
      $display("FAIL %s_timeout: no done within %0d cycles", name, n);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL %s_busy_at_done: busy=%b expected 0", name, busy);
    end
    @(negedge tb_clk);
    tests++;
    if (done !== 1'b0 || done_cnt != 1 || begin_cnt != 10) begin
      fails++;
      $display("FAIL %s_counts: done=%b dones=%0d begins=%0d expected 0 1 10", name, done,
               done_cnt, begin_cnt);
    end
    repeat (5) @(negedge tb_clk);
    tests++;
    if (class_out !== ecls || max_score !== escore) begin
      fails++;
      $display("FAIL %s_hold: class=%0d score=%0d expected %0d %0d", name, class_out,
               $signed(max_score), ecls, $signed(escore));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    repeat (3) @(negedge tb_clk);
    tests++;
    if (row_select !== 4'd0 || begin_mult !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl: row=%0d begin=%b busy=%b done=%b expected all 0", row_select,
               begin_mult, busy, done);
    end
    tests++;
    if (class_out !== 4'd0 || max_score !== 32'd0 || ovf_any !== 1'b0 || err !== 1'b0) begin
      fails++;
      $display("FAIL reset_result: class=%0d score=%0d ovf=%b err=%b expected all 0", class_out,
               max_score, ovf_any, err);
    end
    rst = 1'b0;
    repeat (3) @(negedge tb_clk);
    tests++;
    if (busy !== 1'b0 || begin_mult !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset: busy=%b begin=%b expected 0 0", busy, begin_mult);
    end
  endtask

  task automatic test_basic();
    scores = '{5, -3, 40, 40, 7, 0, -100, 12, 39, 1};
    mdelay = 400; mode = 0; ovf_row = -1; hold_row = -1;
    run_image("basic", 4'd2, 32'd40, 1'b0, -1);
  endtask

  task automatic test_negative();
    scores = '{-9, -2, -50, -8, -3, -60, -2, -11, -100, -7};
    mdelay = 20;
    run_image("negative", 4'd1, -32'sd2, 1'b0, -1);
  endtask

  task automatic test_overflow();
    scores = '{5, -3, 40, 40, 7, 0, -100, 12, 39, 1};
    ovf_row = 6;
    run_image("overflow", 4'd2, 32'd40, 1'b1, -1);
    ovf_row = -1;
    run_image("ovf_cleared", 4'd2, 32'd40, 1'b0, -1);
  endtask

  task automatic test_capture();
    scores = '{10, 20, 30, -5, 99, 98, 99, 0, 1, 2};
    mode = 1;
    run_image("last_strobe_wins", 4'd4, 32'd99, 1'b0, -1);
    scores = '{32'sh8000_0000, -1, 0, 5, 5, 2, 3, 4, 1, 0};
    mode = 2;
    run_image("done_only_capture", 4'd3, 32'd5, 1'b0, -1);
    mode = 0;
  endtask

  task automatic test_busy_start();
    scores = '{5, -3, 40, 40, 7, 0, -100, 12, 39, 1};
    run_image("start_while_busy", 4'd2, 32'd40, 1'b0, 4);
  endtask

  task automatic test_timeout();
    int n;
    scores = '{5, -3, 40, 40, 7, 0, -100, 12, 39, 1};
    hold_row = 3;
    exp_row = 0; begin_cnt = 0; done_cnt = 0;
    pulse_start();
    n = 0;
    while (!(begin_mult === 1'b1 && row_select === 4'd3) && n < 2000) begin
      @(negedge tb_clk); n++;
    end
    tests++;
    if (n >= 2000) begin
      fails++;
      $display("FAIL timeout_row3_launch: row 3 never launched");
    end
    n = 0;
    while (err !== 1'b1 && n < 3000) begin
      @(negedge tb_clk); n++;
    end
    // 1023 WAIT cycles after the LAUNCH cycle, ERROR on the next one
    tests++;
    if (n != 1024) begin
      fails++;
      $display("FAIL timeout_latency: err after %0d cycles expected 1024", n);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL timeout_busy: busy=%b expected 0", busy);
    end
    repeat (5) @(negedge tb_clk);
    tests++;
    if (err !== 1'b1 || done_cnt != 0 || begin_cnt != 4) begin
      fails++;
      $display("FAIL timeout_hold: err=%b dones=%0d begins=%0d expected 1 0 4", err, done_cnt,
               begin_cnt);
    end
    hold_row = -1;
    run_image("after_timeout", 4'd2, 32'd40, 1'b0, -1);
  endtask

  task automatic test_reset_mid();
    int n;
    scores = '{5, -3, 40, 40, 7, 0, -100, 12, 39, 1};
    ovf_row = 2;
    exp_row = 0; begin_cnt = 0; done_cnt = 0;
    pulse_start();
    n = 0;
    while (!(begin_mult === 1'b1 && row_select === 4'd5) && n < 2000) begin
      @(negedge tb_clk); n++;
    end
    repeat (5) @(negedge tb_clk);
    rst = 1'b1;
    #1;
    tests++;
    if (row_select !== 4'd0 || busy !== 1'b0 || begin_mult !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL midreset_ctrl: row=%0d busy=%b begin=%b done=%b expected all 0",
               row_select, busy, begin_mult, done);
    end
    tests++;
    if (class_out !== 4'd0 || max_score !== 32'd0 || ovf_any !== 1'b0 || err !== 1'b0) begin
      fails++;
      $display("FAIL midreset_result: class=%0d score=%0d ovf=%b err=%b expected all 0",
               class_out, max_score, ovf_any, err);
    end
    repeat (3) @(negedge tb_clk);
    rst = 1'b0;
    ovf_row = -1;
    repeat (50) @(negedge tb_clk);
    tests++;
    if (done_cnt != 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL midreset_abandon: dones=%0d busy=%b expected 0 0", done_cnt, busy);
    end
    run_image("after_reset", 4'd2, 32'd40, 1'b0, -1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_overflow();
    test_capture();
    test_busy_start();
    test_timeout();
    test_reset_mid();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d results left expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
